// File: rtl/train_word_tx.sv
// train_word_tx: transmit link-training sequencer for one 12-bit lane.
// It sends the training word until the remote end reports lock, retries on failure,
// and then passes a valid/ready payload stream, filling empty cycles.
// Optional build macro TX_PRBS_FILL_EN: empty payload cycles carry PRBS7 bits instead of IDLE_WORD.
module train_word_tx #(
   parameter logic [15:0] TRAIN_MIN     = 16'd16384,
   parameter logic [19:0] TRAIN_TIMEOUT = 20'd262143,
   parameter logic [2:0]  MAX_RETRY     = 3'd7,
   parameter logic [7:0]  GUARD_CYC     = 8'd64,
   parameter logic [11:0] IDLE_WORD     = 12'h5A5
) (
   input  logic        clk_txg,
   input  logic        rst_tx_n,
   input  logic        cmd_start_training,
   input  logic [11:0] training_word,
   input  logic        rx_training_done,
   input  logic        rx_loc_ok,
   input  logic [11:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [11:0] dataout,
   output logic        tx_train_active,
   output logic        link_up,
   output logic [2:0]  retry_cnt,
   output logic        train_fail
);
   typedef enum logic [2:0] {s_IDLE, s_TRAIN, s_BACKOFF, s_GUARD, s_DATA} state_t;
   localparam logic [19:0] MIN_M1 = 20'(TRAIN_MIN) - 20'd1;
   localparam logic [7:0]  GRD_M1 = GUARD_CYC - 8'd1;
   state_t state, state_n;
   logic [2:0] start_q, done_q, lock_q;
   logic [19:0] cnt_train, cnt_train_n;
   logic [7:0] cnt_guard, cnt_guard_n;
   logic [2:0] retry_n;
   logic fail_n, done_seen, done_seen_n, done_now, train_done;
   logic [11:0] word_n, fill;
   logic start_edge, done_edge, lock, unused_lock;
   assign start_edge  = start_q[1] & ~start_q[2];
   assign done_edge   = done_q[1] & ~done_q[2];
   assign lock        = lock_q[1];
   assign unused_lock = lock_q[2];
   assign done_now    = done_seen | done_edge;
   assign train_done  = done_now && (cnt_train >= MIN_M1);
`ifdef TX_PRBS_FILL_EN
   logic [6:0] lfsr, lfsr_n;
   logic [11:0] prbs_word;
   // Next 12 PRBS7 bits (x^7+x^6+1) and the LFSR state after emitting them.
   always_comb begin
      lfsr_n    = lfsr;
      prbs_word = '0;
      for (int i = 0; i < 12; i++) begin
         prbs_word = {prbs_word[10:0], lfsr_n[6] ^ lfsr_n[5]};
         lfsr_n    = {lfsr_n[5:0], lfsr_n[6] ^ lfsr_n[5]};
      end
   end
   assign fill = prbs_word;
   // Seed on entry to payload mode, advance only on fill cycles.
   always_ff @(posedge clk_txg)
      lfsr <= !rst_tx_n ? 7'h7F :
              (state != s_DATA && state_n == s_DATA) ? 7'h7F :
              (state == s_DATA && !s_valid) ? lfsr_n : lfsr;
`else
   assign fill = IDLE_WORD;
`endif
   // Next-state, counter and output-word selection; a start edge overrides everything.
   always_comb begin
      state_n     = state;
      cnt_train_n = cnt_train;
      cnt_guard_n = cnt_guard;
      retry_n     = retry_cnt;
      fail_n      = train_fail;
      done_seen_n = done_seen;
      word_n      = IDLE_WORD;
      case (state)
         s_IDLE: ;
         s_TRAIN: begin
            word_n      = training_word;
            cnt_train_n = (cnt_train >= TRAIN_TIMEOUT) ? cnt_train : cnt_train + 20'd1;
            done_seen_n = done_now;
            if (train_done && lock) begin
               state_n     = s_GUARD;
               cnt_guard_n = '0;
            end else if (train_done || cnt_train == TRAIN_TIMEOUT) begin
               if (retry_cnt >= MAX_RETRY) begin
                  state_n = s_IDLE;
                  fail_n  = 1'b1;
               end else begin
                  state_n     = s_BACKOFF;
                  retry_n     = retry_cnt + 3'd1;
                  cnt_guard_n = '0;
               end
            end
         end
         s_BACKOFF: begin
            cnt_guard_n = cnt_guard + 8'd1;
            if (cnt_guard >= GRD_M1) begin
               state_n     = s_TRAIN;
               cnt_guard_n = '0;
               cnt_train_n = '0;
               done_seen_n = 1'b0;
            end
         end
         s_GUARD: begin
            word_n      = training_word;
            cnt_guard_n = cnt_guard + 8'd1;
            if (cnt_guard >= GRD_M1) begin
               state_n     = s_DATA;
               cnt_guard_n = '0;
            end
         end
         s_DATA: word_n = s_valid ? s_data : fill;
         default: state_n = s_IDLE;
      endcase
      if (start_edge) begin
         state_n     = s_TRAIN;
         cnt_train_n = '0;
         cnt_guard_n = '0;
         retry_n     = '0;
         fail_n      = 1'b0;
         done_seen_n = 1'b0;
      end
   end
   // State, synchronizers, counters and registered outputs.
   always_ff @(posedge clk_txg) begin
      if (!rst_tx_n) begin
         state           <= s_IDLE;
         start_q         <= '0;
         done_q          <= '0;
         lock_q          <= '0;
         cnt_train       <= '0;
         cnt_guard       <= '0;
         retry_cnt       <= '0;
         train_fail      <= 1'b0;
         done_seen       <= 1'b0;
         dataout         <= IDLE_WORD;
         s_ready         <= 1'b0;
         link_up         <= 1'b0;
         tx_train_active <= 1'b0;
      end else begin
         state           <= state_n;
         start_q         <= {start_q[1:0], cmd_start_training};
         done_q          <= {done_q[1:0], rx_training_done};
         lock_q          <= {lock_q[1:0], rx_loc_ok};
         cnt_train       <= cnt_train_n;
         cnt_guard       <= cnt_guard_n;
         retry_cnt       <= retry_n;
         train_fail      <= fail_n;
         done_seen       <= done_seen_n;
         dataout         <= word_n;
         s_ready         <= state_n == s_DATA;
         link_up         <= state_n == s_DATA;
         tx_train_active <= state_n inside {s_TRAIN, s_GUARD, s_BACKOFF};
      end
   end
endmodule

// File: tb/tb_train_word_tx.sv
// tb_train_word_tx: directed bench for train_word_tx with shortened training parameters.
module tb_train_word_tx;
   logic clk_txg = 1'b0, rst_tx_n = 1'b0, cmd = 1'b0, done = 1'b0, lok = 1'b0, s_valid = 1'b0;
   logic [11:0] tw = 12'hF0C, s_data = '0;
   logic s_ready, tx_train_active, link_up, train_fail;
   logic [11:0] dataout;
   logic [2:0] retry_cnt;
   int tests = 0, fails = 0;
   train_word_tx #(
      .TRAIN_MIN(16'd100), .TRAIN_TIMEOUT(20'd1000), .MAX_RETRY(3'd2), .GUARD_CYC(8'd8), .IDLE_WORD(12'h5A5)
   ) dut (
      .clk_txg(clk_txg), .rst_tx_n(rst_tx_n), .cmd_start_training(cmd), .training_word(tw),
      .rx_training_done(done), .rx_loc_ok(lok), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .dataout(dataout), .tx_train_active(tx_train_active), .link_up(link_up),
      .retry_cnt(retry_cnt), .train_fail(train_fail)
   );
   always #5 clk_txg = ~clk_txg;
   task automatic tick();
      @(posedge clk_txg);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_dataout"}, dataout, 12'h5A5);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_active"}, tx_train_active, 0);
      chk({tag, "_link_up"}, link_up, 0);
      chk({tag, "_retry"}, retry_cnt, 0);
      chk({tag, "_fail"}, train_fail, 0);
   endtask
   task automatic count_idle(input string tag);
      int k = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (dataout === 12'h5A5) k++;
      end
      chk({tag, "_idle_words"}, k, 8);
      chk({tag, "_train_resume"}, dataout, 12'hF0C);
   endtask
   initial begin
      int n;
      repeat (3) tick();
      chk_reset("rst");
      rst_tx_n = 1'b1;
      repeat (20) tick();
      chk_reset("idle");
      // normal lock at training cycle 300, then payload
      cmd = 1'b1;
      n = 0; do begin tick(); n++; end while (!tx_train_active && n < 20);
      chk("t1_start_lat", n, 3);
      tick();
      chk("t1_train_word", dataout, 12'hF0C);
      repeat (299) tick();
      done = 1'b1; lok = 1'b1;
      n = 0; do begin tick(); n++; end while (!link_up && n < 40);
      chk("t1_lock_lat", n, 11);
      chk("t1_guard_word", dataout, 12'hF0C);
      chk("t1_s_ready", s_ready, 1);
      chk("t1_active_off", tx_train_active, 0);
      s_valid = 1'b1; s_data = 12'h123; tick();
      chk("t1_word0", dataout, 12'h123);
      s_data = 12'h456; tick();
      chk("t1_word1", dataout, 12'h456);
      s_valid = 1'b0; tick();
      chk("t1_fill", dataout, 12'h5A5);
      cmd = 1'b0; done = 1'b0;
      repeat (4) tick();
      chk("t1_hold_link", link_up, 1);
      // early done with lock: honoured only from training cycle 99
      cmd = 1'b1;
      n = 0; do begin tick(); n++; end while (!tx_train_active && n < 20);
      chk("t2_start_lat", n, 3);
      chk("t2_link_drop", link_up, 0);
      repeat (48) tick();
      done = 1'b1;
      n = 0; do begin tick(); n++; end while (!link_up && n < 200);
      chk("t2_min_hold", n, 60);
      // stale done level: timeout, two retries, then failure
      cmd = 1'b0;
      repeat (4) tick();
      cmd = 1'b1;
      n = 0; do begin tick(); n++; end while (!tx_train_active && n < 20);
      chk("t3_start_lat", n, 3);
      n = 0; do begin tick(); n++; end while (retry_cnt != 3'd1 && n < 1200);
      chk("t3_timeout1", n, 1001);
      count_idle("t3");
      chk("t3_active_backoff", tx_train_active, 1);
      n = 0; do begin tick(); n++; end while (retry_cnt != 3'd2 && n < 1200);
      chk("t3_timeout2", n, 1000);
      n = 0; do begin tick(); n++; end while (!train_fail && n < 1200);
      chk("t3_fail_lat", n, 1009);
      chk("t3_retry_max", retry_cnt, 2);
      chk("t3_active_off", tx_train_active, 0);
      tick();
      chk("t3_idle_word", dataout, 12'h5A5);
      chk("t3_fail_sticky", train_fail, 1);
      // done without lock: immediate retry
      cmd = 1'b0; done = 1'b0; lok = 1'b0;
      repeat (4) tick();
      cmd = 1'b1;
      n = 0; do begin tick(); n++; end while (!tx_train_active && n < 20);
      chk("t4_start_lat", n, 3);
      chk("t4_fail_clr", train_fail, 0);
      chk("t4_retry_clr", retry_cnt, 0);
      repeat (200) tick();
      done = 1'b1;
      n = 0; do begin tick(); n++; end while (retry_cnt != 3'd1 && n < 20);
      chk("t4_retry_lat", n, 3);
      count_idle("t4");
      // relock, then restart while a payload word is offered
      cmd = 1'b0; done = 1'b0; lok = 1'b1;
      repeat (150) tick();
      done = 1'b1;
      n = 0; do begin tick(); n++; end while (!link_up && n < 40);
      chk("t5_lock_lat", n, 11);
      s_valid = 1'b1; s_data = 12'h111; cmd = 1'b1; tick();
      chk("t5_word0", dataout, 12'h111);
      chk("t5_ready_hold", s_ready, 1);
      s_data = 12'h222; tick();
      chk("t5_word1", dataout, 12'h222);
      s_data = 12'h333; tick();
      chk("t5_last_word", dataout, 12'h333);
      chk("t5_ready_drop", s_ready, 0);
      chk("t5_link_drop", link_up, 0);
      chk("t5_active", tx_train_active, 1);
      s_valid = 1'b0; tick();
      chk("t5_train_word", dataout, 12'hF0C);
      // reset in the middle of training
      cmd = 1'b0;
      repeat (50) tick();
      chk("t6_pre_active", tx_train_active, 1);
      rst_tx_n = 1'b0; tick();
      chk_reset("t6");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
